// File: rtl/decode_pkg.sv
// Shared defaults for the decode stage: datapath widths and the bit positions
// of the control flags the decode stage interprets inside the signals bundle.
package decode_pkg;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_NREGS      = 8;
    localparam int DEF_SIG_W      = 24;
    localparam int DEF_IN_SEL_BIT = 18;
    localparam int DEF_USE1_BIT   = 19;
    localparam int DEF_USE2_BIT   = 20;
    localparam int DEF_MEMRD_BIT  = 21;
endpackage

// File: rtl/reg_file_p.sv
// Parametrised register file: one write port, two combinational read ports
// with write-through bypass so a same-cycle writeback is visible to decode.
module reg_file_p #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_byp1;
    logic              w_byp2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Bypass is suppressed during reset because the write itself is dropped.
    assign w_byp1 = !rst && wb_en && (wb_addr == ra1);
    assign w_byp2 = !rst && wb_en && (wb_addr == ra2);
    assign rd1    = w_byp1 ? wb_data : r_regs[ra1];
    assign rd2    = w_byp2 ? wb_data : r_regs[ra2];
endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: register-file read with bypass, input-port operand select,
// load-use stall generation and the ID/EX pipeline register.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int NREGS      = DEF_NREGS,
    parameter  int SIG_W      = DEF_SIG_W,
    parameter  int IN_SEL_BIT = DEF_IN_SEL_BIT,
    parameter  int USE1_BIT   = DEF_USE1_BIT,
    parameter  int USE2_BIT   = DEF_USE2_BIT,
    parameter  int MEMRD_BIT  = DEF_MEMRD_BIT,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [SIG_W-1:0]  signals_in,
    input  logic [AW-1:0]     rsrc1,
    input  logic [AW-1:0]     rsrc2,
    input  logic [AW-1:0]     rdst,
    input  logic [DATA_W-1:0] in_port,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_out,
    output logic              id_ex_valid,
    output logic [SIG_W-1:0]  id_ex_signals,
    output logic [DATA_W-1:0] id_ex_rd1,
    output logic [DATA_W-1:0] id_ex_rd2,
    output logic [AW-1:0]     id_ex_rsrc1,
    output logic [AW-1:0]     id_ex_rsrc2,
    output logic [AW-1:0]     id_ex_rdst
);
    logic [DATA_W-1:0] w_rf_rd1;
    logic [DATA_W-1:0] w_rf_rd2;
    logic [DATA_W-1:0] w_op1;
    logic              w_dep1;
    logic              w_dep2;
    logic              w_haz;

    logic              r_valid;
    logic [SIG_W-1:0]  r_signals;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [AW-1:0]     r_rsrc1;
    logic [AW-1:0]     r_rsrc2;
    logic [AW-1:0]     r_rdst;

    reg_file_p #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra1     (rsrc1),
        .ra2     (rsrc2),
        .rd1     (w_rf_rd1),
        .rd2     (w_rf_rd2)
    );

    assign w_op1 = signals_in[IN_SEL_BIT] ? in_port : w_rf_rd1;

    // Operand 1 sourced from in_port never depends on the register file.
    assign w_dep1 = signals_in[USE1_BIT] && !signals_in[IN_SEL_BIT] && (r_rdst == rsrc1);
    assign w_dep2 = signals_in[USE2_BIT] && (r_rdst == rsrc2);
    assign w_haz  = in_valid && r_valid && r_signals[MEMRD_BIT] && (w_dep1 || w_dep2);

    assign stall_out = !rst && !flush && (w_haz || hold);

    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && w_haz)) begin
            r_valid   <= 1'b0;
            r_signals <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_rsrc1   <= '0;
            r_rsrc2   <= '0;
            r_rdst    <= '0;
        end else if (!hold) begin
            r_valid   <= in_valid;
            r_signals <= in_valid ? signals_in : '0;
            r_rd1     <= w_op1;
            r_rd2     <= w_rf_rd2;
            r_rsrc1   <= rsrc1;
            r_rsrc2   <= rsrc2;
            r_rdst    <= rdst;
        end
    end

    assign id_ex_valid   = r_valid;
    assign id_ex_signals = r_signals;
    assign id_ex_rd1     = r_rd1;
    assign id_ex_rd2     = r_rd2;
    assign id_ex_rsrc1   = r_rsrc1;
    assign id_ex_rsrc2   = r_rsrc2;
    assign id_ex_rdst    = r_rdst;
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed scenarios plus randomized traffic checked
// against a behavioural model, and a 32-bit/16-register instance.
module tb_decode_stage_p;
    localparam int INS = 18;
    localparam int U1  = 19;
    localparam int U2  = 20;
    localparam int MR  = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance signals
    logic        in_valid, wb_en, flush, hold;
    logic [23:0] sig;
    logic [2:0]  rsrc1, rsrc2, rdst, wb_addr;
    logic [15:0] in_port, wb_data;
    logic        stall_out, id_ex_valid;
    logic [23:0] id_ex_signals;
    logic [15:0] id_ex_rd1, id_ex_rd2;
    logic [2:0]  id_ex_rsrc1, id_ex_rsrc2, id_ex_rdst;

    // wide instance signals
    logic        b_in_valid, b_wb_en, b_flush, b_hold;
    logic [23:0] b_sig;
    logic [3:0]  b_rsrc1, b_rsrc2, b_rdst, b_wb_addr;
    logic [31:0] b_in_port, b_wb_data;
    logic        b_stall_out, b_id_ex_valid;
    logic [23:0] b_id_ex_signals;
    logic [31:0] b_id_ex_rd1, b_id_ex_rd2;
    logic [3:0]  b_id_ex_rsrc1, b_id_ex_rsrc2, b_id_ex_rdst;

    decode_stage_p dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signals_in(sig),
        .rsrc1(rsrc1), .rsrc2(rsrc2), .rdst(rdst), .in_port(in_port),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .hold(hold), .stall_out(stall_out),
        .id_ex_valid(id_ex_valid), .id_ex_signals(id_ex_signals),
        .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2),
        .id_ex_rsrc1(id_ex_rsrc1), .id_ex_rsrc2(id_ex_rsrc2), .id_ex_rdst(id_ex_rdst)
    );

    decode_stage_p #(.DATA_W(32), .NREGS(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .signals_in(b_sig),
        .rsrc1(b_rsrc1), .rsrc2(b_rsrc2), .rdst(b_rdst), .in_port(b_in_port),
        .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
        .flush(b_flush), .hold(b_hold), .stall_out(b_stall_out),
        .id_ex_valid(b_id_ex_valid), .id_ex_signals(b_id_ex_signals),
        .id_ex_rd1(b_id_ex_rd1), .id_ex_rd2(b_id_ex_rd2),
        .id_ex_rsrc1(b_id_ex_rsrc1), .id_ex_rsrc2(b_id_ex_rsrc2), .id_ex_rdst(b_id_ex_rdst)
    );

    int n_vec = 0;
    int n_err = 0;

    // behavioural model of the architectural state seen by the default instance
    logic [15:0] m_regs [8];
    logic        m_v;
    logic [23:0] m_sig;
    logic [15:0] m_rd1, m_rd2;
    logic [2:0]  m_rs1, m_rs2, m_rdst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (!rst && wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic m_clear_idex();
        m_v = 1'b0; m_sig = '0; m_rd1 = '0; m_rd2 = '0;
        m_rs1 = '0; m_rs2 = '0; m_rdst = '0;
    endtask

    // One clock of the default instance: check stall before the edge, then
    // advance the model and compare every ID/EX output after the edge.
    task automatic step();
        logic        h;
        logic [15:0] o1, o2;
        #1;
        h = in_valid && m_v && m_sig[MR] &&
            ((sig[U1] && !sig[INS] && m_rdst == rsrc1) || (sig[U2] && m_rdst == rsrc2));
        chk("stall_out", stall_out, !rst && !flush && (h || hold));
        o1 = sig[INS] ? in_port : m_read(rsrc1);
        o2 = m_read(rsrc2);
        @(posedge clk);
        #1;
        if (rst || flush || (!hold && h)) begin
            m_clear_idex();
        end else if (!hold) begin
            m_v = in_valid; m_sig = in_valid ? sig : '0;
            m_rd1 = o1; m_rd2 = o2; m_rs1 = rsrc1; m_rs2 = rsrc2; m_rdst = rdst;
        end
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
        end else if (wb_en) begin
            m_regs[wb_addr] = wb_data;
        end
        chk("id_ex_valid", id_ex_valid, m_v);
        chk("id_ex_signals", id_ex_signals, m_sig);
        chk("id_ex_rd1", id_ex_rd1, m_rd1);
        chk("id_ex_rd2", id_ex_rd2, m_rd2);
        chk("id_ex_rsrc1", id_ex_rsrc1, m_rs1);
        chk("id_ex_rsrc2", id_ex_rsrc2, m_rs2);
        chk("id_ex_rdst", id_ex_rdst, m_rdst);
    endtask

    task automatic idle();
        in_valid = 0; sig = '0; rsrc1 = '0; rsrc2 = '0; rdst = '0; in_port = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0; hold = 0;
    endtask

    task automatic instr(input logic [23:0] s, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d);
        in_valid = 1; sig = s; rsrc1 = a; rsrc2 = b; rdst = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        b_in_valid = 0; b_sig = '0; b_rsrc1 = '0; b_rsrc2 = '0; b_rdst = '0;
        b_in_port = '0; b_wb_en = 0; b_wb_addr = '0; b_wb_data = '0; b_flush = 0; b_hold = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'hxxxx;
        m_clear_idex();
        tick();

        // reset with writebacks active: nothing may land in the register file
        for (int i = 0; i < 3; i++) begin
            instr(24'($urandom), 3'(i), 3'(i + 1), 3'(i));
            wb_en = 1; wb_addr = 3'(i + 2); wb_data = 16'($urandom); hold = 1;
            step();
        end
        rst = 0;
        idle();
        step();
        for (int i = 0; i < 8; i++) begin
            instr('0, 3'(i), 3'(7 - i), 3'(i));
            step();
            chk("reset_reg_rd1", id_ex_rd1, 16'h0);
            chk("reset_reg_rd2", id_ex_rd2, 16'h0);
        end

        // write-through bypass, then the stored value
        idle();
        instr('0, 3'd3, 3'd0, 3'd5);
        wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
        step();
        chk("bypass_rd1", id_ex_rd1, 16'hBEEF);
        idle();
        instr('0, 3'd3, 3'd3, 3'd5);
        step();
        chk("stored_r3", id_ex_rd2, 16'hBEEF);

        // input port overrides register operand 1
        idle();
        wb_en = 1; wb_addr = 3'd1; wb_data = 16'h0055;
        step();
        idle();
        instr(24'(1) << INS, 3'd1, 3'd1, 3'd2);
        in_port = 16'h1234;
        step();
        chk("inport_rd1", id_ex_rd1, 16'h1234);
        chk("inport_rd2", id_ex_rd2, 16'h0055);

        // load-use: one bubble, then the consumer captures
        idle();
        instr(24'(1) << MR, 3'd0, 3'd0, 3'd2);
        step();
        instr(24'(1) << U2, 3'd0, 3'd2, 3'd4);
        #1 chk("lu_stall", stall_out, 1'b1);
        step();
        chk("lu_bubble_valid", id_ex_valid, 1'b0);
        chk("lu_bubble_sig", id_ex_signals, 24'h0);
        step();
        chk("lu_capture_valid", id_ex_valid, 1'b1);

        // flush beats hold; then hold alone freezes ID/EX
        idle();
        instr(24'h0000A5, 3'd3, 3'd1, 3'd6);
        flush = 1; hold = 1;
        #1 chk("flush_stall", stall_out, 1'b0);
        step();
        chk("flush_valid", id_ex_valid, 1'b0);
        idle();
        instr(24'h0000FF, 3'd3, 3'd1, 3'd6);
        step();
        hold = 1;
        instr(24'h000011, 3'd2, 3'd2, 3'd2);
        step();
        step();
        chk("hold_valid", id_ex_valid, 1'b1);
        chk("hold_rd1", id_ex_rd1, 16'hBEEF);
        chk("hold_sig", id_ex_signals, 24'h0000FF);

        // randomized traffic with occasional reset, flush and hold
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            sig      = 24'($urandom);
            sig[MR]  = ($urandom_range(0, 2) == 0);
            sig[INS] = ($urandom_range(0, 4) == 0);
            rsrc1    = 3'($urandom); rsrc2 = 3'($urandom); rdst = 3'($urandom);
            in_port  = 16'($urandom);
            wb_en    = $urandom_range(0, 1) == 1;
            wb_addr  = 3'($urandom); wb_data = 16'($urandom);
            flush    = ($urandom_range(0, 9) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        // wide instance: 32-bit data, 4-bit addresses
        b_wb_en = 1; b_wb_addr = 4'd15; b_wb_data = 32'hDEADBEEF;
        tick();
        b_wb_en = 0;
        b_in_valid = 1; b_sig = 24'(1) << MR; b_rsrc1 = 4'd15; b_rsrc2 = 4'd0; b_rdst = 4'd15;
        #1 chk("w_stall0", b_stall_out, 1'b0);
        tick();
        chk("w_r15", b_id_ex_rd1, 32'hDEADBEEF);
        chk("w_rdst", b_id_ex_rdst, 4'd15);
        b_sig = (24'(1) << U2) | (24'(1) << MR); b_rsrc2 = 4'd7; b_rdst = 4'd15;
        #1 chk("w_nohaz_r7", b_stall_out, 1'b0);
        tick();
        chk("w_cap_valid", b_id_ex_valid, 1'b1);
        b_sig = 24'(1) << U2; b_rsrc2 = 4'd15; b_rdst = 4'd3;
        #1 chk("w_haz_r15", b_stall_out, 1'b1);
        tick();
        chk("w_bubble", b_id_ex_valid, 1'b0);
        #1 chk("w_stall_clear", b_stall_out, 1'b0);
        tick();
        chk("w_dep_valid", b_id_ex_valid, 1'b1);
        chk("w_dep_rd2", b_id_ex_rd2, 32'hDEADBEEF);
        chk("w_dep_rsrc2", b_id_ex_rsrc2, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised decode stage for the pipelined core. It contains a parametrised register file with write-through bypass and the input-port operand select. It also owns the ID/EX pipeline register and generates the load-use stall. Control signals arrive already decoded from the control unit; outputs feed the execute stage, and the stall goes back to fetch.

Parameters:
- DATA_W, 16, datapath and register width.
- NREGS, 8, number of architectural registers (power of 2, ≥2).
- AW, $clog2(NREGS), register address width (derived, not overridable).
- SIG_W, 24, control signal bundle width.
- IN_SEL_BIT, 18, signals bit: operand 1 comes from in_port.
- USE1_BIT, 19, signals bit: instruction reads rsrc1.
- USE2_BIT, 20, signals bit: instruction reads rsrc2.
- MEMRD_BIT, 21, signals bit: instruction is a load.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  IF/ID holds a valid instruction.
- signals_in  in  SIG_W  decoded control bundle for the IF/ID instruction.
- rsrc1, rsrc2, rdst  in  AW  register fields of the IF/ID instruction.
- in_port  in  DATA_W  external input port value.
- wb_en  in  1  writeback enable.
- wb_addr  in  AW  writeback register.
- wb_data  in  DATA_W  writeback value.
- flush  in  1  squash the instruction entering EX (branch/exception).
- hold  in  1  downstream stall; freeze ID/EX.
- stall_out  out  1  to fetch; hold PC and IF/ID this cycle.
- id_ex_valid  out  1  ID/EX register holds a real instruction.
- id_ex_signals  out  SIG_W  registered control bundle.
- id_ex_rd1, id_ex_rd2  out  DATA_W  registered operands.
- id_ex_rsrc1, id_ex_rsrc2, id_ex_rdst  out  AW  registered register fields, used for forwarding.

Behaviour:
- Register file: NREGS×DATA_W. All entries reset to 0 on rst. Written at the clock edge when wb_en && !rst. Every register is writable; there is no hard-wired zero.
- Reads are combinational with write-through bypass: if wb_en && wb_addr==rsrcN, the read returns wb_data. A write during rst is ignored, and the bypass is also ignored during rst.
- Operand 1 = signals_in[IN_SEL_BIT] ? in_port : bypassed read of rsrc1. Operand 2 = bypassed read of rsrc2.
- Load-use hazard: haz = in_valid && id_ex_valid && id_ex_signals[MEMRD_BIT] && ((signals_in[USE1_BIT] && !signals_in[IN_SEL_BIT] && id_ex_rdst==rsrc1) || (signals_in[USE2_BIT] && id_ex_rdst==rsrc2)).
- stall_out = !rst && !flush && (haz || hold). It is combinational in the same cycle.
- ID/EX update priority at each edge:
  - rst: all id_ex_* outputs become 0.
  - flush (with hold or haz also present, flush wins): valid=0, signals=0, data and address fields=0.
  - hold: all id_ex_* keep their values.
  - haz: insert bubble (valid=0, signals=0, data and address fields=0).
  - otherwise: capture; valid=in_valid; signals=in_valid?signals_in:0; rd1/rd2/rsrc/rdst captured.
- Latency: decode to ID/EX outputs is 1 cycle. A load-use pair costs exactly one bubble, then the dependent instruction captures on the following edge.
- During hold, held operands are not refreshed by writebacks; downstream forwarding covers this.
- Reset mid-stall clears everything. stall_out is 0 during rst.

Decomposition:
- decode_pkg: default widths and the signals bit indices (IN_SEL_BIT, USE1_BIT, USE2_BIT, MEMRD_BIT).
- Sub-module reg_file_p (DATA_W, NREGS) contains the storage, write port and two bypassed read ports.
- Hazard logic, operand mux and the ID/EX register live in decode_stage_p.

Test Plan:
- Reset: run 3 cycles with wb writes active, then release rst → all regs read 0, id_ex_valid=0, stall_out=0.
- Bypass: wb_en=1, wb_addr=3, wb_data=16'hBEEF, rsrc1=3, in_valid=1 in the same cycle → next edge id_ex_rd1=16'hBEEF; R3 reads BEEF afterwards.
- Input port: signals_in[IN_SEL_BIT]=1, in_port=16'h1234, R1=16'h0055, rsrc1=1 → id_ex_rd1=16'h1234.
- Load-use: load to R2 in ID/EX, next instruction USE2 with rsrc2=2 → stall_out=1 for one cycle, bubble (valid=0, signals=0); next edge the instruction captures with valid=1.
- Flush vs hold: flush=1 and hold=1 together with a valid instruction → next edge valid=0, stall_out=0. hold alone for 2 cycles → id_ex_* unchanged, stall_out=1.
- Parametrisation: DATA_W=32, NREGS=16; write R15=32'hDEADBEEF, then read → matches; hazard compare uses the full 4-bit address.
